// File: rtl/usr_arb_ctrl.sv
// Two-requester round-robin arbiter that sequences an external 4-bit universal shift register.
// Optional macro USR_ARB_CTRL_ROTATE_EN: op 11 rotates right; otherwise op 11 acts as SHR with fill.
//
// state  | meaning
// IDLE   | no owner, waiting for a request
// LOAD   | parallel-load latched data into the shift register
// SHIFT  | N shift cycles per latched op/cnt
// DONE   | completion pulse to owner, result presented
module usr_arb_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  input  logic [3:0] data0,
  input  logic [3:0] data1,
  input  logic [1:0] cnt0,
  input  logic [1:0] cnt1,
  input  logic       fill0,
  input  logic       fill1,
  output logic       grant0,
  output logic       grant1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic [1:0] usr_s,
  output logic [3:0] usr_in,
  output logic       usr_sir,
  output logic       usr_sil,
  input  logic [3:0] usr_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE} state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [1:0] op_q, op_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] data_q, data_d;
  logic       fill_q, fill_d;
  logic       pick;

  // last_q holds the index served most recently; reset value 1 gives req0 priority
  always_comb begin
    if (req0 && req1) pick = ~last_q;
    else              pick = req1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 2'b00;
      cnt_q   <= 2'b00;
      data_q  <= 4'b0000;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    fill_d  = fill_q;
    usr_s   = 2'b00;
    usr_in  = 4'b0000;
    usr_sir = 1'b0;
    usr_sil = 1'b0;
    result  = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = pick;
          last_d  = pick;
          op_d    = pick ? op1   : op0;
          data_d  = pick ? data1 : data0;
          cnt_d   = pick ? cnt1  : cnt0;
          fill_d  = pick ? fill1 : fill0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        usr_s   = 2'b11;
        usr_in  = data_q;
        state_d = (op_q == 2'b00) ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        case (op_q)
          2'b10: begin
            usr_s   = 2'b10;
            usr_sil = fill_q;
          end
          2'b11: begin
            usr_s   = 2'b01;
`ifdef USR_ARB_CTRL_ROTATE_EN
            usr_sir = usr_out[0];
`else
            usr_sir = fill_q;
`endif
          end
          default: begin
            usr_s   = 2'b01;
            usr_sir = fill_q;
          end
        endcase
        // cnt_q counts remaining shifts minus one, so cnt+1 shift cycles occur
        if (cnt_q == 2'b00) state_d = ST_DONE;
        else                cnt_d   = cnt_q - 2'd1;
      end
      ST_DONE: begin
        result  = usr_out;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant0 = (state_q != ST_IDLE) && !owner_q;
  assign grant1 = (state_q != ST_IDLE) &&  owner_q;
  assign done0  = (state_q == ST_DONE) && !owner_q;
  assign done1  = (state_q == ST_DONE) &&  owner_q;

endmodule

// File: tb/tb_usr_arb_ctrl.sv
// Self-checking bench for usr_arb_ctrl: external shift register model, closed-form result
// reference and round-robin ordering model, with directed cases followed by random traffic.
module tb_usr_arb_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, fill0, fill1;
  logic [1:0] op0, op1, cnt0, cnt1;
  logic [3:0] data0, data1;
  logic       grant0, grant1, done0, done1;
  logic [3:0] result;
  logic [1:0] usr_s;
  logic [3:0] usr_in;
  logic       usr_sir, usr_sil;
  logic [3:0] usr_out;

  logic       dr_req[2], dr_fill[2];
  logic [1:0] dr_op[2], dr_cnt[2];
  logic [3:0] dr_data[2];
  logic       m_fill[2];
  logic [1:0] m_op[2], m_cnt[2];
  logic [3:0] m_data[2];
  bit         pend[2];
  int         rr_last;
  int         vectors = 0;
  int         miscompares = 0;

`ifdef USR_ARB_CTRL_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  assign req0 = dr_req[0];   assign req1 = dr_req[1];
  assign op0 = dr_op[0];     assign op1 = dr_op[1];
  assign data0 = dr_data[0]; assign data1 = dr_data[1];
  assign cnt0 = dr_cnt[0];   assign cnt1 = dr_cnt[1];
  assign fill0 = dr_fill[0]; assign fill1 = dr_fill[1];

  // external universal shift register driven by the controller
  logic [3:0] sreg = 4'b0000;
  always @(posedge clk) begin
    case (usr_s)
      2'b01: sreg <= {usr_sir, sreg[3:1]};
      2'b10: sreg <= {sreg[2:0], usr_sil};
      2'b11: sreg <= usr_in;
      default: sreg <= sreg;
    endcase
  end
  assign usr_out = sreg;

  usr_arb_ctrl dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .data0(data0), .data1(data1), .cnt0(cnt0), .cnt1(cnt1),
    .fill0(fill0), .fill1(fill1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .result(result), .usr_s(usr_s), .usr_in(usr_in),
    .usr_sir(usr_sir), .usr_sil(usr_sil), .usr_out(usr_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_result(input logic [1:0] op, input logic [3:0] d,
                                            input logic [1:0] c, input logic f);
    int v, n;
    v = int'(d);
    n = int'(c) + 1;
    if (op == 2'd0)
      return d;
    else if (op == 2'd2)
      v = ((v << n) & 15) | (f ? ((1 << n) - 1) : 0);
    else if (op == 2'd3 && ROT_EN)
      v = ((v >> n) | (v << (4 - n))) & 15;
    else
      v = (v >> n) | (f ? ((15 << (4 - n)) & 15) : 0);
    return v[3:0];
  endfunction

  task automatic start(input int i, input logic [1:0] op, input logic [3:0] data,
                       input logic [1:0] cnt, input logic fill);
    dr_op[i] = op;   dr_data[i] = data; dr_cnt[i] = cnt; dr_fill[i] = fill;
    m_op[i]  = op;   m_data[i]  = data; m_cnt[i]  = cnt; m_fill[i]  = fill;
    dr_req[i] = 1'b1;
    pend[i] = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, {grant1, grant0}, 0);
    chk({tag, "_done"}, {done1, done0}, 0);
    chk({tag, "_outs"}, {usr_s, usr_in, usr_sir, usr_sil, result}, 0);
  endtask

  // called at a negedge with the DUT idle and at least one request pending
  task automatic serve_one(input bit drop_early);
    int w, n, d;
    logic [3:0] exp;
    logic [1:0] mode;
    if (pend[0] && pend[1]) w = (rr_last == 0) ? 1 : 0;
    else                    w = pend[1] ? 1 : 0;
    n = (m_op[w] == 2'd0) ? 0 : int'(m_cnt[w]) + 1;
    d = 1 + n;
    exp = ref_result(m_op[w], m_data[w], m_cnt[w], m_fill[w]);
    mode = (m_op[w] == 2'd2) ? 2'b10 : 2'b01;
    @(negedge clk);
    chk("grant_owner", w ? grant1 : grant0, 1);
    chk("grant_other", w ? grant0 : grant1, 0);
    chk("load_mode", usr_s, 2'b11);
    chk("load_data", usr_in, m_data[w]);
    dr_op[w] = 2'($urandom); dr_data[w] = 4'($urandom);
    dr_cnt[w] = 2'($urandom); dr_fill[w] = 1'($urandom);
    if (drop_early) dr_req[w] = 1'b0;
    for (int c = 1; c < d; c++) begin
      @(negedge clk);
      chk("shift_mode", usr_s, mode);
      chk("shift_grant", {grant1, grant0}, w ? 2 : 1);
      chk("shift_nodone", {done1, done0}, 0);
    end
    @(negedge clk);
    chk("done_pulse", {done1, done0}, w ? 2 : 1);
    chk("done_grant", {grant1, grant0}, w ? 2 : 1);
    chk("result", result, exp);
    chk("done_mode", usr_s, 0);
    dr_req[w] = 1'b0;
    pend[w] = 1'b0;
    rr_last = w;
    @(negedge clk);
    chk_idle("after_done");
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      dr_req[i] = 0; dr_op[i] = 0; dr_data[i] = 0; dr_cnt[i] = 0; dr_fill[i] = 0;
      pend[i] = 0;
    end
    rr_last = 1;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("reset");
    reset = 1'b1;

    start(0, 2'd0, 4'b1010, 2'd0, 1'b0);
    serve_one(0);
    start(1, 2'd2, 4'b0011, 2'd1, 1'b1);
    serve_one(0);
    start(0, 2'd1, 4'b1100, 2'd0, 1'b0);
    serve_one(0);
    start(0, 2'd3, 4'b1011, 2'd0, 1'b0);
    serve_one(0);

    // simultaneous requests, twice
    for (int r = 0; r < 2; r++) begin
      start(0, 2'd0, 4'($urandom), 2'd0, 1'b0);
      start(1, 2'd0, 4'($urandom), 2'd0, 1'b0);
      serve_one(0);
      serve_one(0);
    end

    // requester drops req right after being granted
    start(1, 2'd2, 4'b0101, 2'd2, 1'b0);
    serve_one(1);

    // reset in the middle of a 4-cycle shift
    start(0, 2'd2, 4'b0101, 2'd3, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_idle("async_reset");
    dr_req[0] = 1'b0;
    pend[0] = 1'b0;
    rr_last = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_idle("in_reset");
    end
    reset = 1'b1;
    start(1, 2'd1, 4'b1001, 2'd1, 1'b0);
    serve_one(0);

    for (int it = 0; it < 250; it++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && ($urandom_range(1, 0) == 1))
          start(i, 2'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      if (!pend[0] && !pend[1]) begin
        if ($urandom_range(3, 0) == 0) begin
          @(negedge clk);
          chk_idle("idle_gap");
        end
        start(int'($urandom_range(1, 0)), 2'($urandom), 4'($urandom), 2'($urandom), 1'($urandom));
      end
      serve_one($urandom_range(3, 0) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usr_arb_ctrl.md
USR_ARB_CTRL -- requirements
Module: usr_arb_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: req0, req1  in  1 each  requester operation requests, held until matching done.
REQ-004 SHALL have: op0, op1  in  2 each  opcode: 00 LOAD, 01 LOAD+SHR, 10 LOAD+SHL, 11 LOAD+ROTR.
REQ-005 SHALL have: data0, data1  in  4 each  parallel load value.
REQ-006 SHALL have: cnt0, cnt1  in  2 each  shift count minus one (N = cnt+1, range 1..4); ignored for LOAD.
REQ-007 SHALL have: fill0, fill1  in  1 each  serial fill bit for SHR/SHL.
REQ-008 SHALL have: grant0, grant1  out  1 each  requester owns the shift register.
REQ-009 SHALL have: done0, done1  out  1 each  one-cycle completion pulse.
REQ-010 SHALL have: result  out  4  final register value, valid while any done is high.
REQ-011 SHALL have: usr_s  out  2, usr_in  out  4, usr_sir  out  1, usr_sil  out  1, usr_out  in  4  to/from the shift register.

Function
REQ-012 SHALL drive the shift register with the mode contract: usr_s 00 hold, 01 shift right (out <= {sir, out[3:1]}), 10 shift left (out <= {out[2:0], sil}), 11 parallel load.
REQ-013 SHALL implement FSM IDLE, LOAD, SHIFT, DONE; transitions below only.
REQ-014 IDLE: any req high at edge t -> grant one requester, latch its op/data/cnt/fill, go LOAD; else stay.
REQ-015 Arbitration SHALL be round-robin: single request wins; simultaneous requests go to the requester not served last; after reset req0 has priority.
REQ-016 LOAD: usr_s=11, usr_in=latched data for one cycle; next state SHIFT if op!=00, else DONE.
REQ-017 SHIFT: exactly N cycles; SHR usr_s=01, usr_sir=fill; SHL usr_s=10, usr_sil=fill; ROTR usr_s=01, usr_sir=usr_out[0]; then DONE.
REQ-018 DONE: usr_s=00, done of granted requester=1, result=usr_out, one cycle, then IDLE with grant dropped.
REQ-019 Latency: req seen at edge t -> done high in the cycle after edge t+1 (LOAD) or t+1+N (shift ops); next grant no earlier than edge t+3+N (N=0 for LOAD).
REQ-020 grant SHALL be high from edge t through the DONE cycle; exactly one grant at a time.
REQ-021 Latched operands SHALL be used; requester input changes after edge t SHALL have no effect.
REQ-022 Requester dropping req mid-operation SHALL NOT abort; operation completes and done still pulses.
REQ-023 In IDLE: usr_s=00, usr_in=0000, usr_sir=0, usr_sil=0, result=0000.

Reset
REQ-024 reset low SHALL immediately force IDLE, grant0/1=0, done0/1=0, result=0000, usr_s=00, usr_in=0000, usr_sir=usr_sil=0, round-robin pointer to req0.
REQ-025 Reset asserted mid-LOAD/SHIFT SHALL abandon the operation with no done pulse; register contents are undefined to requesters.
REQ-026 After reset release, first request SHALL be sampled on the first rising edge.

Configuration
REQ-027 Macro USR_ARB_CTRL_ROTATE_EN: defined -> op 11 rotates right per REQ-017.
REQ-028 Undefined -> op 11 SHALL behave exactly as op 01 (SHR with fill); no other behaviour change.

Verification
REQ-029 req0, op=00, data=1010 -> grant0 next cycle, done0 one cycle later, result=1010, usr_s sequence 11,00.
REQ-030 req1, op=10, data=0011, cnt=01, fill=1 -> two SHL cycles, result=1111, done1 pulse once.
REQ-031 req0, op=01, data=1100, cnt=00, fill=0 -> result=0110; op=11, data=1011, cnt=00 -> 1101 with ROTATE_EN, 0101 without.
REQ-032 req0 and req1 high together after reset, both op=00 -> req0 served first, req1 granted next; repeat -> order alternates.
REQ-033 reset low during SHIFT of a cnt=11 operation -> all outputs reach reset values asynchronously, no done, new request served normally after release.
REQ-034 req1 dropped one cycle after grant -> operation completes, done1 pulses, result correct.
